transmissor_matriz_serial: RTL
==============================

// Module: transmissor_matriz_serial
// PURPOSE
//   Serial transmitter that reads a stored 8-bit row pattern and an address and
//   shifts them out as one 16-bit frame to the LED-matrix driver chip.
//   Frame format is MAX7219-style: {4'b0000, endereco[3:0], dado[7:0]}, MSB first.
//   Sits between the game's row/data registers and the matrix driver pins.
//   Start/busy/done handshake toward the control unit.
// PARAMETERS
//   DIVISOR  4  system clocks per SCLK half-period; legal values >= 1
// PORTS
//   clock     in   1  system clock; all state changes on its rising edge
//   clear     in   1  reset, asynchronous, active-high
//   iniciar   in   1  start request; sampled only in OCIOSO
//   endereco  in   4  driver register address; captured at the accepting edge
//   dado      in   8  row pattern; captured at the accepting edge
//   sclk      out  1  serial clock to driver (registered)
//   sdout     out  1  serial data to driver (registered)
//   cs_n      out  1  chip-select/load, active-low; driver latches on its rising edge
//   ocupado   out  1  high while a frame is in progress
//   pronto    out  1  one-cycle pulse when a frame completes
// BEHAVIOUR
// - Reset (clear=1, async): sclk=0, sdout=0, cs_n=1, ocupado=0, pronto=0.
//   Reset also clears the state (OCIOSO), the shift register, and the counters.
// - All outputs are driven directly from flops. No combinational paths from
//   inputs to outputs.
// - States: OCIOSO, BAIXO (sclk=0), ALTO (sclk=1), FINAL.
// - OCIOSO with iniciar=1 at edge E0:
//   - Latch {4'b0000,endereco,dado} into a 16-bit shift register.
//   - cs_n<=0, ocupado<=1, sdout<=bit15, bit index<=15, go to BAIXO.
// - BAIXO lasts DIVISOR cycles, then go to ALTO (sclk<=1).
//   The driver samples sdout on this rising sclk edge.
// - ALTO lasts DIVISOR cycles. On exit:
//   - If index>0: sclk<=0, shift, sdout<=next bit, index-1, go to BAIXO.
//   - If index=0: sclk<=0, go to FINAL.
// - sdout changes only on falling sclk, so it is stable for the whole high phase.
// - FINAL: sclk=0 and cs_n=0 are held for DIVISOR cycles. On exit:
//   cs_n<=1, ocupado<=0, pronto<=1 for exactly one cycle, sdout<=0, go to OCIOSO.
// - Latency: ocupado is high for exactly 33*DIVISOR cycles (edges E0..E0+33*DIVISOR).
//   Each frame has exactly 16 sclk rising edges.
// - iniciar while ocupado=1 is ignored: no queuing and no effect on the current frame.
//   endereco/dado changes during a frame are likewise ignored.
// - Back-to-back: iniciar may be high in the pronto cycle; the next frame starts
//   on the following edge. Minimum cs_n high time between frames is 1 cycle.
// - clear mid-frame aborts immediately: cs_n rises, sclk falls, and no pronto is
//   issued. The driver may latch a partial frame; the control unit rewrites it.
// - Counters are sized for DIVISOR up to 255. The bit index is 4 bits and
//   does not wrap: the terminal test is index==0 in ALTO.
// TESTING
// - Reset: hold clear mid-operation -> sclk=0, sdout=0, cs_n=1, ocupado=0,
//   pronto=0 asynchronously, before the next clock.
// - DIVISOR=4, endereco=4'h1, dado=8'hA5, iniciar pulse -> sdout sampled at the
//   16 sclk rises = 16'h01A5. ocupado high for 132 cycles. cs_n rises on the
//   same edge as the single pronto pulse.
// - Start during frame: pulse iniciar at bit 7 with dado=8'h00 -> frame still
//   16'h01A5. Exactly one pronto. No extra sclk edges.
// - Back-to-back: iniciar held high, endereco=4'hC, dado=8'h01 -> repeated
//   16'h0C01 frames. cs_n high exactly 1 cycle between frames; pronto once per frame.
// - Abort: clear at bit 7 -> immediate idle outputs, no pronto. Then start with
//   endereco=4'h3, dado=8'h3C -> full frame 16'h033C.
// - DIVISOR=1, endereco=4'hF, dado=8'hFF -> frame 16'h0FFF (bits 15:12 zero).
//   ocupado high for 33 cycles; sclk period 2 cycles.

Source files
------------

// File: rtl/transmissor_matriz_serial.sv
// rtl/transmissor_matriz_serial.sv - serial frame transmitter for the LED-matrix driver
//
// Shifts one 16-bit frame {4'b0000, endereco, dado} out MSB first.
// The frame is framed by cs_n, and the driver latches the frame on the rising edge of cs_n.
// sdout changes only on falling sclk, so the driver samples it on rising sclk.
//
// Ports:
//   clock    system clock (rising edge)
//   clear    asynchronous active-high reset
//   iniciar  start request, sampled only while idle
//   endereco driver register address, captured on the accepting edge
//   dado     row pattern, captured on the accepting edge
//   sclk     serial clock to driver (registered)
//   sdout    serial data to driver (registered)
//   cs_n     active-low chip select / load (registered)
//   ocupado  high while a frame is in progress
//   pronto   one-cycle pulse when a frame completes

module transmissor_matriz_serial #(
  parameter int DIVISOR = 4
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       iniciar,
  input  logic [3:0] endereco,
  input  logic [7:0] dado,
  output logic       sclk,
  output logic       sdout,
  output logic       cs_n,
  output logic       ocupado,
  output logic       pronto
);

  typedef enum logic [1:0] {
    OCIOSO,
    BAIXO,
    ALTO,
    FINAL
  } estado_t;

  // Terminal count of every phase (each phase lasts DIVISOR cycles).
  localparam logic [7:0] LIMITE = 8'(DIVISOR - 1);

  estado_t     estado;
  logic [14:0] restante;   // bits still to be sent after the one on sdout
  logic [3:0]  indice;     // index of the bit currently on sdout
  logic [7:0]  contador;   // cycles spent in the current phase
  logic [15:0] quadro;
  logic        fim_fase;

  assign quadro   = {4'b0000, endereco, dado};
  assign fim_fase = (contador == LIMITE);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      estado   <= OCIOSO;
      restante <= '0;
      indice   <= '0;
      contador <= '0;
      sclk     <= 1'b0;
      sdout    <= 1'b0;
      cs_n     <= 1'b1;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            restante <= quadro[14:0];
            sdout    <= quadro[15];
            indice   <= 4'd15;
            contador <= '0;
            cs_n     <= 1'b0;
            ocupado  <= 1'b1;
            estado   <= BAIXO;
          end
        end

        BAIXO: begin
          if (fim_fase) begin
            contador <= '0;
            sclk     <= 1'b1;
            estado   <= ALTO;
          end else begin
            contador <= contador + 8'd1;
          end
        end

        ALTO: begin
          if (fim_fase) begin
            contador <= '0;
            sclk     <= 1'b0;
            // The last bit stays on sdout through FINAL; the index never wraps.
            if (indice != 4'd0) begin
              sdout    <= restante[14];
              restante <= {restante[13:0], 1'b0};
              indice   <= indice - 4'd1;
              estado   <= BAIXO;
            end else begin
              estado <= FINAL;
            end
          end else begin
            contador <= contador + 8'd1;
          end
        end

        FINAL: begin
          if (fim_fase) begin
            contador <= '0;
            cs_n     <= 1'b1;
            ocupado  <= 1'b0;
            pronto   <= 1'b1;
            sdout    <= 1'b0;
            estado   <= OCIOSO;
          end else begin
            contador <= contador + 8'd1;
          end
        end

        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule
